// File: rtl/vec_pkg.sv
// Shared definitions for the vector execute unit.
//   VEC_* constants : default geometry (16 lanes x 16b = 256b, 8 vector registers)
//   vop_e           : 3-bit opcode encoding seen on op_code
//   vstate_e        : execute-unit FSM states
package vec_pkg;

  localparam int unsigned VEC_LANES   = 16;
  localparam int unsigned VEC_LANE_W  = 16;
  localparam int unsigned VEC_VREG_AW = 3;
  localparam int unsigned VEC_DOT_LPC = 4;
  localparam int unsigned VEC_OPC_W   = 3;

  typedef enum logic [VEC_OPC_W-1:0] {
    OP_VADD  = 3'b000,
    OP_VSUB  = 3'b001,
    OP_VMUL  = 3'b010,
    OP_VDOT  = 3'b011,
    OP_VSMUL = 3'b100,
    OP_VAND  = 3'b101,
    OP_VOR   = 3'b110,
    OP_VXOR  = 3'b111
  } vop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_EX   = 2'd2,
    ST_WB   = 2'd3
  } vstate_e;

endpackage

// File: rtl/vector_lane_alu.sv
// Combinational single-lane ALU, replicated once per lane.
//   a_i, b_i  : lane operands from Va / Vb
//   scalar_i  : latched scalar operand (VSMUL)
//   op_i      : latched opcode
//   y_o       : lane result, wraps mod 2^LANE_W; 0 for VDOT (reduced in the top)
module vector_lane_alu
  import vec_pkg::*;
#(
  parameter int unsigned LANE_W = VEC_LANE_W
) (
  input  logic [LANE_W-1:0] a_i,
  input  logic [LANE_W-1:0] b_i,
  input  logic [LANE_W-1:0] scalar_i,
  input  vop_e              op_i,
  output logic [LANE_W-1:0] y_o
);

  always_comb begin
    y_o = '0;
    unique case (op_i)
      OP_VADD:  y_o = a_i + b_i;
      OP_VSUB:  y_o = a_i - b_i;
      OP_VMUL:  y_o = a_i * b_i;       // LANE_W-wide context keeps the low half
      OP_VSMUL: y_o = a_i * scalar_i;
      OP_VAND:  y_o = a_i & b_i;
      OP_VOR:   y_o = a_i | b_i;
      OP_VXOR:  y_o = a_i ^ b_i;
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/vector_exec_unit.sv
// Non-pipelined vector execute stage sitting behind an 8x256b register file.
//   op_valid/op_ready       : op handshake, accepted in IDLE or WB
//   op_code/srcA/srcB/dst   : op fields, latched at accept
//   op_scalar               : VSMUL scalar, latched at accept
//   VreadA/VreadB           : register-file read addresses (held from RD through EX)
//   Va/Vb                   : registered read data, valid the cycle after the address
//   Vwrdata/VwrAddr/VwrEn   : writeback port; write commits at the end of WB
//   busy                    : op in flight
//   done                    : 1-cycle pulse with VwrEn
module vector_exec_unit
  import vec_pkg::*;
#(
  parameter int unsigned LANES   = VEC_LANES,
  parameter int unsigned LANE_W  = VEC_LANE_W,
  parameter int unsigned VREG_AW = VEC_VREG_AW,
  parameter int unsigned DOT_LPC = VEC_DOT_LPC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [VEC_OPC_W-1:0]      op_code,
  input  logic [VREG_AW-1:0]        op_srcA,
  input  logic [VREG_AW-1:0]        op_srcB,
  input  logic [VREG_AW-1:0]        op_dst,
  input  logic [LANE_W-1:0]         op_scalar,
  output logic [VREG_AW-1:0]        VreadA,
  output logic [VREG_AW-1:0]        VreadB,
  input  logic [LANES*LANE_W-1:0]   Va,
  input  logic [LANES*LANE_W-1:0]   Vb,
  output logic [LANES*LANE_W-1:0]   Vwrdata,
  output logic [VREG_AW-1:0]        VwrAddr,
  output logic                      VwrEn,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned VW      = LANES * LANE_W;
  localparam int unsigned ACC_W   = 2 * LANE_W;
  localparam int unsigned DOT_CYC = LANES / DOT_LPC;
  localparam int unsigned CNT_W   = $clog2(DOT_CYC);
  localparam int unsigned LANE_IW = $clog2(LANES);

  vstate_e state_q, state_d;

  vop_e                op_q;
  logic [VREG_AW-1:0]  srca_q, srcb_q, dst_q;
  logic [LANE_W-1:0]   scalar_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ACC_W-1:0]    acc_q;
  logic [VW-1:0]       res_q;

  logic                accept;
  logic                dot_last;
  logic [VW-1:0]       lane_res;
  logic [ACC_W-1:0]    dot_sum;
  logic [VW-1:0]       dot_res;

  logic [LANE_W-1:0]   va_lane [LANES];
  logic [LANE_W-1:0]   vb_lane [LANES];

  assign accept   = op_valid && op_ready;
  assign dot_last = (cnt_q == CNT_W'(DOT_CYC - 1));

  // ---------------- lane ALUs ----------------
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign va_lane[g] = Va[g*LANE_W +: LANE_W];
    assign vb_lane[g] = Vb[g*LANE_W +: LANE_W];

    vector_lane_alu #(.LANE_W(LANE_W)) u_alu (
      .a_i      (va_lane[g]),
      .b_i      (vb_lane[g]),
      .scalar_i (scalar_q),
      .op_i     (op_q),
      .y_o      (lane_res[g*LANE_W +: LANE_W])
    );
  end

  // ---------------- dot-product slice ----------------
  // Cycle k of EX folds lanes k*DOT_LPC .. k*DOT_LPC+DOT_LPC-1 into the accumulator.
  always_comb begin
    logic signed [LANE_W-1:0] la, lb;
    logic signed [ACC_W-1:0]  prod;
    logic [LANE_IW-1:0]       idx;
    dot_sum = acc_q;
    la      = '0;
    lb      = '0;
    prod    = '0;
    idx     = '0;
    for (int unsigned j = 0; j < DOT_LPC; j++) begin
      idx     = LANE_IW'(32'(cnt_q) * DOT_LPC + j);
      la      = va_lane[idx];
      lb      = vb_lane[idx];
      prod    = la * lb;
      dot_sum = dot_sum + prod;
    end
    dot_res            = '0;
    dot_res[ACC_W-1:0] = dot_sum;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_RD;
      ST_RD:   state_d = ST_EX;
      ST_EX:   if (op_q != OP_VDOT || dot_last) state_d = ST_WB;
      ST_WB:   state_d = accept ? ST_RD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    op_ready = (state_q == ST_IDLE) || (state_q == ST_WB);
    VwrEn    = (state_q == ST_WB);
    done     = (state_q == ST_WB);
    busy     = (state_q != ST_IDLE);
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_VADD;
      srca_q   <= '0;
      srcb_q   <= '0;
      dst_q    <= '0;
      scalar_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      res_q    <= '0;
    end else begin
      if (accept) begin
        op_q     <= vop_e'(op_code);
        srca_q   <= op_srcA;
        srcb_q   <= op_srcB;
        dst_q    <= op_dst;
        scalar_q <= op_scalar;
      end
      if (state_q == ST_RD) begin
        cnt_q <= '0;
        acc_q <= '0;
      end
      if (state_q == ST_EX) begin
        if (op_q == OP_VDOT) begin
          cnt_q <= cnt_q + 1'b1;
          acc_q <= dot_sum;
          if (dot_last) res_q <= dot_res;
        end else begin
          res_q <= lane_res;
        end
      end
    end
  end

  // Addresses come straight from the latched fields so they stay put through EX
  // and only move on the next accept, which is after the commit of this op.
  assign VreadA  = srca_q;
  assign VreadB  = srcb_q;
  assign VwrAddr = dst_q;
  assign Vwrdata = res_q;

endmodule
